// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Brief    : Shared state encodings, winner codes and playfield widths for the
//            pong game sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SERVE = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_t;

    localparam logic [1:0] c_win_none  = 2'b00;
    localparam logic [1:0] c_win_left  = 2'b01;
    localparam logic [1:0] c_win_right = 2'b10;

    localparam int c_x_w     = 10;
    localparam int c_y_w     = 9;
    localparam int c_score_w = 4;

    // A point is a fresh transition out of "no winner"; 2'b11 never scores.
    function automatic logic is_point(input logic [1:0] winner, input logic [1:0] winner_q);
        return ((winner == c_win_left) || (winner == c_win_right)) && (winner_q == c_win_none);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_timer
// Brief    : Free-running frame counter producing a registered one-cycle tick.
// Revision : 1.0 - initial release
// ============================================================================
module pong_frame_timer #(
    parameter int FRAME_CYCLES = 833333
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_frame_tick
);

    localparam int                 c_cnt_w = $clog2(FRAME_CYCLES);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(FRAME_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_count;
    logic               r_tick;
    logic               w_wrap;

    assign w_wrap = (r_count == c_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_tick  <= w_wrap;
            r_count <= w_wrap ? '0 : (r_count + c_one);
        end
    end

    assign o_frame_tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/pong_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pong_game_sequencer
// Brief    : Game controller: serve/play sequencing, scoring, CPU hold and
//            frame-synchronous ball coordinate publishing.
// Revision : 1.0 - initial release
// ============================================================================
module pong_game_sequencer
    import pong_pkg::*;
#(
    parameter int FRAME_CYCLES = 833333,
    parameter int SERVE_FRAMES = 60,
    parameter int WIN_SCORE    = 7,
    parameter int XLIM         = 639,
    parameter int YLIM         = 479
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           winner,
    input  logic [c_x_w-1:0]     ball_x_in,
    input  logic [c_y_w-1:0]     ball_y_in,
    output logic                 cpu_reset,
    output logic [c_x_w-1:0]     ball_xlim,
    output logic [c_y_w-1:0]     ball_ylim,
    output logic                 frame_tick,
    output logic [c_x_w-1:0]     ball_x,
    output logic [c_y_w-1:0]     ball_y,
    output logic [c_score_w-1:0] score_l,
    output logic [c_score_w-1:0] score_r,
    output logic [1:0]           state,
    output logic                 game_over,
    output logic [1:0]           champion
);

    localparam int                   c_serve_w    = $clog2(SERVE_FRAMES + 1);
    localparam logic [c_serve_w-1:0] c_serve_last = c_serve_w'(SERVE_FRAMES - 1);
    localparam logic [c_serve_w-1:0] c_serve_one  = c_serve_w'(1);
    localparam logic [c_score_w-1:0] c_win_score  = c_score_w'(WIN_SCORE);
    localparam logic [c_score_w-1:0] c_score_one  = c_score_w'(1);
    localparam logic [c_x_w-1:0]     c_xlim       = c_x_w'(XLIM);
    localparam logic [c_y_w-1:0]     c_ylim       = c_y_w'(YLIM);
    localparam logic [c_x_w-1:0]     c_ball_x_ctr = c_x_w'(XLIM / 2);
    localparam logic [c_y_w-1:0]     c_ball_y_ctr = c_y_w'(YLIM / 2);

    state_t                 r_state, w_state_next;
    logic                   r_cpu_reset, r_game_over, r_start_q;
    logic [1:0]             r_winner_q, r_champion, w_champion_next;
    logic [c_serve_w-1:0]   r_serve_cnt, w_serve_cnt_next;
    logic [c_score_w-1:0]   r_score_l, r_score_r, w_score_l_next, w_score_r_next;
    logic [c_score_w-1:0]   w_score_l_inc, w_score_r_inc;
    logic [c_x_w-1:0]       r_ball_x, w_ball_x_next;
    logic [c_y_w-1:0]       r_ball_y, w_ball_y_next;
    logic                   w_frame_tick, w_start_evt, w_point;

    pong_frame_timer #(
        .FRAME_CYCLES (FRAME_CYCLES)
    ) u_frame_timer (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .o_frame_tick (w_frame_tick)
    );

    assign w_start_evt   = start & ~r_start_q;
    assign w_point       = is_point(winner, r_winner_q);
    assign w_score_l_inc = r_score_l + c_score_one;
    assign w_score_r_inc = r_score_r + c_score_one;

    always_comb begin
        w_state_next     = r_state;
        w_serve_cnt_next = r_serve_cnt;
        w_score_l_next   = r_score_l;
        w_score_r_next   = r_score_r;
        w_champion_next  = r_champion;
        w_ball_x_next    = r_ball_x;
        w_ball_y_next    = r_ball_y;

        case (r_state)
            ST_IDLE: begin
                if (w_start_evt) begin
                    w_state_next     = ST_SERVE;
                    w_serve_cnt_next = '0;
                    w_score_l_next   = '0;
                    w_score_r_next   = '0;
                end
            end
            ST_SERVE: begin
                if (w_frame_tick) begin
                    if (r_serve_cnt == c_serve_last) begin
                        w_state_next = ST_PLAY;
                    end else begin
                        w_serve_cnt_next = r_serve_cnt + c_serve_one;
                    end
                end
            end
            ST_PLAY: begin
                // A point outranks a simultaneous frame tick: the ball is not latched.
                if (w_point) begin
                    w_serve_cnt_next = '0;
                    w_state_next     = ST_SERVE;
                    if (winner == c_win_left) begin
                        w_score_l_next = w_score_l_inc;
                        if (w_score_l_inc == c_win_score) begin
                            w_state_next    = ST_OVER;
                            w_champion_next = c_win_left;
                        end
                    end else begin
                        w_score_r_next = w_score_r_inc;
                        if (w_score_r_inc == c_win_score) begin
                            w_state_next    = ST_OVER;
                            w_champion_next = c_win_right;
                        end
                    end
                end else if (w_frame_tick) begin
                    w_ball_x_next = ball_x_in;
                    w_ball_y_next = ball_y_in;
                end
            end
            ST_OVER: begin
                if (w_start_evt) begin
                    w_state_next     = ST_SERVE;
                    w_serve_cnt_next = '0;
                    w_score_l_next   = '0;
                    w_score_r_next   = '0;
                    w_champion_next  = c_win_none;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        if (w_state_next == ST_SERVE) begin
            w_ball_x_next = c_ball_x_ctr;
            w_ball_y_next = c_ball_y_ctr;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_cpu_reset <= 1'b1;
            r_game_over <= 1'b0;
            r_serve_cnt <= '0;
            r_score_l   <= '0;
            r_score_r   <= '0;
            r_champion  <= c_win_none;
            r_ball_x    <= c_ball_x_ctr;
            r_ball_y    <= c_ball_y_ctr;
            r_start_q   <= 1'b0;
            r_winner_q  <= c_win_none;
        end else begin
            r_state     <= w_state_next;
            r_cpu_reset <= (w_state_next != ST_PLAY);
            r_game_over <= (w_state_next == ST_OVER);
            r_serve_cnt <= w_serve_cnt_next;
            r_score_l   <= w_score_l_next;
            r_score_r   <= w_score_r_next;
            r_champion  <= w_champion_next;
            r_ball_x    <= w_ball_x_next;
            r_ball_y    <= w_ball_y_next;
            r_start_q   <= start;
            r_winner_q  <= winner;
        end
    end

    assign cpu_reset  = r_cpu_reset;
    assign ball_xlim  = c_xlim;
    assign ball_ylim  = c_ylim;
    assign frame_tick = w_frame_tick;
    assign ball_x     = r_ball_x;
    assign ball_y     = r_ball_y;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign state      = r_state;
    assign game_over  = r_game_over;
    assign champion   = r_champion;

endmodule
`default_nettype wire

// File: doc/pong_game_sequencer.md
# pong_game_sequencer

Top-level game controller that sequences the pong processor subsystem (processor, register file, memories). It holds the CPU in reset between rallies and drives the playfield limits into the register file. It detects the point-winner the register file reports, keeps the score, and publishes frame-synchronous ball coordinates to the display path. It sits between the board-level clock/reset/start inputs and the processor subsystem.

## Interface
Parameters:
- FRAME_CYCLES, 833333, clock cycles per display frame (60 Hz at 50 MHz); must be ≥ 2
- SERVE_FRAMES, 60, frame ticks spent in SERVE before play; must be ≥ 1
- WIN_SCORE, 7, points that end the game; range 1..15
- XLIM, 639, playfield x limit driven to ball_xlim
- YLIM, 479, playfield y limit driven to ball_ylim

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  debounced start button, level; rising edge is the event
- winner  in  2  from regfile: 00 none, 01 left, 10 right, 11 invalid (ignored)
- ball_x_in  in  10  live ball x from regfile
- ball_y_in  in  9  live ball y from regfile
- cpu_reset  out  1  active-high hold to processor and regfile
- ball_xlim  out  10  constant XLIM
- ball_ylim  out  9  constant YLIM
- frame_tick  out  1  one-cycle pulse per frame
- ball_x  out  10  frame-latched ball x
- ball_y  out  9  frame-latched ball y
- score_l  out  4  left score
- score_r  out  4  right score
- state  out  2  IDLE=00, SERVE=01, PLAY=10, OVER=11
- game_over  out  1  high in OVER
- champion  out  2  01 left / 10 right in OVER, else 00

## Operation
- Reset values: state IDLE, cpu_reset 1, frame counter 0, frame_tick 0, serve counter 0, scores 0, game_over 0, champion 00, ball_x XLIM/2 (integer division), ball_y YLIM/2, start_q 0, winner_q 00.
- Frame timer is free-running in every state. It counts 0..FRAME_CYCLES-1. frame_tick is registered and high for the cycle after the count equals FRAME_CYCLES-1. The count wraps to 0.
- Start event = start & ~start_q.
- IDLE:
  - cpu_reset 1.
  - Start event → SERVE; scores cleared.
- SERVE:
  - cpu_reset 1; ball_x/ball_y forced to centre.
  - Entry clears the serve counter.
  - Each frame_tick increments the serve counter.
  - frame_tick with counter = SERVE_FRAMES-1 → PLAY.
- PLAY:
  - cpu_reset 0; start ignored.
  - On each frame_tick, ball_x ← ball_x_in and ball_y ← ball_y_in.
  - Point event = winner ∈ {01,10} and winner_q = 00.
  - A point event increments the matching score.
  - If the new score equals WIN_SCORE → OVER, with champion set to the winning side. Otherwise → SERVE.
- OVER:
  - cpu_reset 1; game_over 1; scores and ball held.
  - Start event → SERVE with scores cleared and champion 00.
- winner = 11 is never a point event. winner_q still tracks it.
- Point event coinciding with frame_tick in PLAY: the point wins. The state leaves PLAY and the ball is not latched.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- Start event sampled at edge N → state, cpu_reset and score changes are visible after edge N.
- Point event at edge N:
  - score, state and cpu_reset=1 are visible after edge N.
  - The regfile clears winner under cpu_reset no later than edge N+1.
  - winner_q blocks a double count.
- SERVE lasts from SERVE_FRAMES-1 to SERVE_FRAMES full frames, depending on entry phase.
- cpu_reset deasserts on the same edge that state becomes PLAY.
- Asserting reset mid-game returns immediately to reset values, including the frame counter.

## Structure
- Shared package pong_pkg holds:
  - state encodings IDLE/SERVE/PLAY/OVER
  - winner codes NONE/LEFT/RIGHT
  - playfield width constants (10-bit x, 9-bit y)
- Sub-module pong_frame_timer contains the frame counter and tick pulse, parameterised by FRAME_CYCLES.
- The state machine, scoring and latching stay in pong_game_sequencer.

## Test plan
Bench parameters: FRAME_CYCLES=10, SERVE_FRAMES=2, WIN_SCORE=3.
- Reset then idle 50 cycles → state 00, cpu_reset 1, frame_tick pulses every 10 cycles, ball_x 319, ball_y 239.
- Start pulse → state 01 next cycle; 11–20 cycles later state 10 and cpu_reset 0 on the same edge.
- In PLAY, ball_x_in=100, ball_y_in=50 → ball_x/ball_y read 100/50 only after the next frame_tick, unchanged before it.
- winner 00→01 held 3 cycles → score_l 1 (single increment), state 01, cpu_reset 1; winner=11 in PLAY → no score change.
- Three right points → score_r 3, state 11, game_over 1, champion 10; start → scores 0, champion 00, state 01.
- reset asserted mid-PLAY with score_l 2 → immediately state 00, scores 0, cpu_reset 1, frame counter restarts.
